id_ex_stage: RTL and testbench

//  ID/EX pipeline register plus operand forwarding for the 16-bit WISC core. Captures decoded

---
 rtl/wisc_pkg.sv | 49 ++++
 rtl/id_ex_stage_fwd_unit.sv | 47 ++++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// ============================================================================
// Module : wisc_pkg
// Brief  : Shared widths, opcode encoding and ID/EX pipeline entry type
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wisc_pkg;

    localparam int WISC_DATA_W     = 16;
    localparam int WISC_REG_ADDR_W = 4;
    localparam int WISC_OP_W       = 4;

    typedef enum logic [WISC_OP_W-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LHB    = 4'b1010,
        OP_LLB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    typedef struct packed {
        logic                       valid;
        opcode_e                    opcode;
        logic [WISC_REG_ADDR_W-1:0] rs_addr;
        logic [WISC_REG_ADDR_W-1:0] rt_addr;
        logic [WISC_REG_ADDR_W-1:0] rd_addr;
        logic [WISC_DATA_W-1:0]     rs_data;
        logic [WISC_DATA_W-1:0]     rt_data;
        logic [WISC_DATA_W-1:0]     imm;
        logic                       use_imm;
        logic                       reg_write;
        logic                       mem_read;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_fwd_unit.sv
// ============================================================================
// Module : fwd_unit
// Brief  : Operand forwarding mux for one source register (EX/MEM over MEM/WB)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fwd_unit
    import wisc_pkg::*;
#(
    parameter int DATA_W     = WISC_DATA_W,
    parameter int REG_ADDR_W = WISC_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr_i,
    input  logic [DATA_W-1:0]     reg_data_i,
    input  logic                  exmem_reg_write_i,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr_i,
    input  logic [DATA_W-1:0]     exmem_result_i,
    input  logic                  memwb_reg_write_i,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr_i,
    input  logic [DATA_W-1:0]     memwb_result_i,
    output logic [DATA_W-1:0]     operand_o
);

    logic w_exmem_hit;
    logic w_memwb_hit;

    assign w_exmem_hit = exmem_reg_write_i && (exmem_rd_addr_i != '0)
                         && (exmem_rd_addr_i == src_addr_i);
    assign w_memwb_hit = memwb_reg_write_i && (memwb_rd_addr_i != '0)
                         && (memwb_rd_addr_i == src_addr_i);

    // R0 is hard-wired to zero, so it wins even over a stale register read.
    always_comb begin
        operand_o = reg_data_i;
        if (src_addr_i == '0) begin
            operand_o = '0;
        end else if (w_exmem_hit) begin
            operand_o = exmem_result_i;
        end else if (w_memwb_hit) begin
            operand_o = memwb_result_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with operand forwarding and load-use detect
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
    import wisc_pkg::*;
#(
    // Must match the package widths, since the pipeline entry is a package type.
    parameter int DATA_W     = WISC_DATA_W,
    parameter int REG_ADDR_W = WISC_REG_ADDR_W,
    parameter int OP_W       = WISC_OP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [OP_W-1:0]       id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic                  id_use_imm,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd_addr,
    input  logic [DATA_W-1:0]     exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd_addr,
    input  logic [DATA_W-1:0]     memwb_result,
    output logic                  ex_valid,
    output logic [OP_W-1:0]       ex_opcode,
    output logic [DATA_W-1:0]     ex_alu_a,
    output logic [DATA_W-1:0]     ex_alu_b,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_sub,
    output logic                  ex_is_psa,
    output logic                  load_use_stall
);

    id_ex_t             entry_q;
    id_ex_t             entry_d;
    id_ex_t             w_id_entry;
    logic [DATA_W-1:0]  w_fwd_a;
    logic [DATA_W-1:0]  w_fwd_b;

    always_comb begin
        w_id_entry           = '0;
        w_id_entry.valid     = id_valid;
        w_id_entry.opcode    = opcode_e'(id_opcode);
        w_id_entry.rs_addr   = id_rs_addr;
        w_id_entry.rt_addr   = id_rt_addr;
        w_id_entry.rd_addr   = id_rd_addr;
        w_id_entry.rs_data   = id_rs_data;
        w_id_entry.rt_data   = id_rt_data;
        w_id_entry.imm       = id_imm;
        w_id_entry.use_imm   = id_use_imm;
        w_id_entry.reg_write = id_reg_write;
        w_id_entry.mem_read  = id_mem_read;
    end

    // Flush beats stall: a stalled entry is still turned into a bubble in place.
    always_comb begin
        entry_d = entry_q;
        if (flush) begin
            if (!stall) begin
                entry_d = w_id_entry;
            end
            entry_d.valid = 1'b0;
        end else if (!stall) begin
            entry_d = w_id_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    fwd_unit #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .src_addr_i        (entry_q.rs_addr),
        .reg_data_i        (entry_q.rs_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_addr_i   (exmem_rd_addr),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_addr_i   (memwb_rd_addr),
        .memwb_result_i    (memwb_result),
        .operand_o         (w_fwd_a)
    );

    fwd_unit #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .src_addr_i        (entry_q.rt_addr),
        .reg_data_i        (entry_q.rt_data),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_rd_addr_i   (exmem_rd_addr),
        .exmem_result_i    (exmem_result),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_rd_addr_i   (memwb_rd_addr),
        .memwb_result_i    (memwb_result),
        .operand_o         (w_fwd_b)
    );

    assign ex_valid     = entry_q.valid;
    assign ex_opcode    = entry_q.opcode;
    assign ex_rd_addr   = entry_q.rd_addr;
    assign ex_alu_a     = w_fwd_a;
    assign ex_alu_b     = entry_q.use_imm ? entry_q.imm : w_fwd_b;
    assign ex_reg_write = entry_q.valid & entry_q.reg_write;
    assign ex_sub       = entry_q.valid & (entry_q.opcode == OP_SUB);
    assign ex_is_psa    = entry_q.valid & (entry_q.opcode == OP_PADDSB);

    // Looks at the live decode addresses, so it must not be masked by stall.
    assign load_use_stall = entry_q.valid & entry_q.mem_read
                            & (entry_q.rd_addr != '0)
                            & ((entry_q.rd_addr == id_rs_addr)
                               | (entry_q.rd_addr == id_rt_addr));

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module : tb_id_ex_stage
// Brief  : Table-driven, scoreboarded bench for the ID/EX stage
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, id_valid;
    logic [3:0]  id_opcode, id_rs_addr, id_rt_addr, id_rd_addr;
    logic [15:0] id_rs_data, id_rt_data, id_imm;
    logic        id_use_imm, id_reg_write, id_mem_read;
    logic        exmem_reg_write, memwb_reg_write;
    logic [3:0]  exmem_rd_addr, memwb_rd_addr;
    logic [15:0] exmem_result, memwb_result;
    logic        ex_valid, ex_reg_write, ex_sub, ex_is_psa, load_use_stall;
    logic [3:0]  ex_opcode, ex_rd_addr;
    logic [15:0] ex_alu_a, ex_alu_b;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_opcode       (id_opcode),
        .id_rs_addr      (id_rs_addr),
        .id_rt_addr      (id_rt_addr),
        .id_rd_addr      (id_rd_addr),
        .id_rs_data      (id_rs_data),
        .id_rt_data      (id_rt_data),
        .id_imm          (id_imm),
        .id_use_imm      (id_use_imm),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd_addr   (exmem_rd_addr),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd_addr   (memwb_rd_addr),
        .memwb_result    (memwb_result),
        .ex_valid        (ex_valid),
        .ex_opcode       (ex_opcode),
        .ex_alu_a        (ex_alu_a),
        .ex_alu_b        (ex_alu_b),
        .ex_rd_addr      (ex_rd_addr),
        .ex_reg_write    (ex_reg_write),
        .ex_sub          (ex_sub),
        .ex_is_psa       (ex_is_psa),
        .load_use_stall  (load_use_stall)
    );

    typedef struct {
        logic        fl, vld;
        logic [3:0]  op, rs, rt, rd;
        logic [15:0] rs_d, rt_d, imm;
        logic        ui, rw, mr;
        logic        xw; logic [3:0] xrd; logic [15:0] xres;
        logic        ww; logic [3:0] wrd; logic [15:0] wres;
        logic        e_vld; logic [15:0] e_a, e_b;
        logic        e_rw, e_sub, e_psa;
    } vec_t;

    typedef struct {
        logic        vld;
        logic [3:0]  op, rd;
        logic [15:0] a, b;
        logic        rw, sub, psa, lus;
    } exp_t;

    vec_t tbl[11];
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(e.vld));
        chk({tag, ".opcode"}, 32'(ex_opcode), 32'(e.op));
        chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(e.rd));
        chk({tag, ".alu_a"}, 32'(ex_alu_a), 32'(e.a));
        chk({tag, ".alu_b"}, 32'(ex_alu_b), 32'(e.b));
        chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(e.rw));
        chk({tag, ".sub"}, 32'(ex_sub), 32'(e.sub));
        chk({tag, ".psa"}, 32'(ex_is_psa), 32'(e.psa));
        chk({tag, ".lus"}, 32'(load_use_stall), 32'(e.lus));
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; id_valid = 0; id_opcode = 0;
        id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_use_imm = 0; id_reg_write = 0; id_mem_read = 0;
    endtask

    task automatic clear_wb();
        exmem_reg_write = 0; exmem_rd_addr = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd_addr = 0; memwb_result = 0;
    endtask

    task automatic drive_id(input logic vld, input logic [3:0] op, rs, rt, rd,
                            input logic [15:0] rsd, rtd, imm,
                            input logic ui, rw, mr);
        id_valid = vld; id_opcode = op; id_rs_addr = rs; id_rt_addr = rt;
        id_rd_addr = rd; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
    endtask

    // Drive one table entry; the writeback ports are applied while it sits in EX.
    task automatic apply_vec(input int idx);
        vec_t v;
        exp_t e;
        v = tbl[idx];
        clear_wb();
        drive_id(v.vld, v.op, v.rs, v.rt, v.rd, v.rs_d, v.rt_d, v.imm, v.ui, v.rw, v.mr);
        flush = v.fl;
        e.vld = v.e_vld; e.op = v.op; e.rd = v.rd; e.a = v.e_a; e.b = v.e_b;
        e.rw = v.e_rw; e.sub = v.e_sub; e.psa = v.e_psa; e.lus = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        exmem_reg_write = v.xw; exmem_rd_addr = v.xrd; exmem_result = v.xres;
        memwb_reg_write = v.ww; memwb_rd_addr = v.wrd; memwb_result = v.wres;
        #1;
        if (sb_q.size() == 0) begin
            chk($sformatf("vec%0d.scoreboard_empty", idx), 32'd0, 32'd1);
        end else begin
            check_all($sformatf("vec%0d", idx), sb_q.pop_front());
        end
    endtask

    initial begin
        exp_t e;
        //             fl vld op    rs    rt    rd    rs_d      rt_d      imm       ui rw mr  xw xrd   xres      ww wrd   wres      ev a         b         rw sub psa
        tbl[0]  = '{0, 1, 4'h0, 4'h1, 4'h2, 4'h5, 16'h0005, 16'h0003, 16'h0000, 0, 1, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0005, 16'h0003, 1, 0, 0};
        tbl[1]  = '{0, 1, 4'h1, 4'h3, 4'h4, 4'h6, 16'h1111, 16'h2222, 16'h0000, 0, 1, 0, 1, 4'h3, 16'h1234, 1, 4'h3, 16'hBEEF, 1, 16'h1234, 16'h2222, 1, 1, 0};
        tbl[2]  = '{0, 1, 4'h2, 4'h3, 4'h6, 4'h7, 16'h1111, 16'h0006, 16'h0000, 0, 1, 0, 1, 4'h0, 16'h1234, 1, 4'h3, 16'hBEEF, 1, 16'hBEEF, 16'h0006, 1, 0, 0};
        tbl[3]  = '{0, 1, 4'h7, 4'h0, 4'h7, 4'h8, 16'hFFFF, 16'h0707, 16'h0000, 0, 1, 0, 1, 4'h7, 16'h7777, 1, 4'h0, 16'hAAAA, 1, 16'h0000, 16'h7777, 1, 0, 1};
        tbl[4]  = '{0, 1, 4'hB, 4'h5, 4'h5, 4'h9, 16'h5555, 16'h5555, 16'h00AB, 1, 1, 0, 1, 4'h5, 16'h9999, 0, 4'h0, 16'h0000, 1, 16'h9999, 16'h00AB, 1, 0, 0};
        tbl[5]  = '{0, 1, 4'h1, 4'h8, 4'h9, 4'hA, 16'h0001, 16'h0009, 16'h0000, 0, 1, 0, 0, 4'h8, 16'h1111, 1, 4'h8, 16'hC0DE, 1, 16'hC0DE, 16'h0009, 1, 1, 0};
        tbl[6]  = '{1, 1, 4'h1, 4'h1, 4'h2, 4'h3, 16'h0101, 16'h0202, 16'h0000, 0, 1, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 16'h0101, 16'h0202, 0, 0, 0};
        tbl[7]  = '{0, 0, 4'h0, 4'h1, 4'h2, 4'h3, 16'h0011, 16'h0022, 16'h0000, 0, 1, 0, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 0, 16'h0011, 16'h0022, 0, 0, 0};
        tbl[8]  = '{0, 1, 4'h3, 4'hA, 4'hA, 4'hC, 16'h00F0, 16'h00F0, 16'h0000, 0, 1, 0, 1, 4'hB, 16'h0001, 1, 4'hA, 16'h0FF0, 1, 16'h0FF0, 16'h0FF0, 1, 0, 0};
        tbl[9]  = '{0, 1, 4'h9, 4'h2, 4'h2, 4'h0, 16'h0002, 16'h0002, 16'h0010, 1, 0, 0, 1, 4'h2, 16'h4444, 0, 4'h0, 16'h0000, 1, 16'h4444, 16'h0010, 0, 0, 0};
        tbl[10] = '{0, 1, 4'h8, 4'h1, 4'h0, 4'h4, 16'h0002, 16'h0000, 16'h0004, 1, 1, 1, 0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 1, 16'h0002, 16'h0004, 1, 0, 0};

        // Reset with live decode activity: everything must read back as zero.
        idle_inputs();
        clear_wb();
        rst = 1;
        drive_id(1, 4'h7, 4'h1, 4'h2, 4'h3, 16'h1234, 16'h5678, 16'h9ABC, 0, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        e = '{0, 4'h0, 4'h0, 16'h0, 16'h0, 0, 0, 0, 0};
        check_all("reset", e);
        rst = 0;
        idle_inputs();

        for (int i = 0; i < 11; i++) apply_vec(i);

        // Load-use: LW r4 in EX, decode reads r4 as rt.
        clear_wb();
        drive_id(1, 4'h8, 4'h1, 4'h0, 4'h4, 16'h0010, 16'h0000, 16'h0002, 1, 1, 1);
        @(posedge clk);
        #1;
        drive_id(1, 4'h0, 4'h1, 4'h4, 4'h6, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
        #1;
        chk("lu.hit_rt", 32'(load_use_stall), 32'd1);
        id_rt_addr = 4'h5;
        #1;
        chk("lu.no_hit", 32'(load_use_stall), 32'd0);
        id_rs_addr = 4'h4;
        #1;
        chk("lu.hit_rs", 32'(load_use_stall), 32'd1);
        stall = 1; flush = 1;
        @(posedge clk);
        #1;
        chk("lu.bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu.bubble_rw", 32'(ex_reg_write), 32'd0);
        chk("lu.bubble_lus", 32'(load_use_stall), 32'd0);
        chk("lu.bubble_rd_held", 32'(ex_rd_addr), 32'd4);
        idle_inputs();

        // PADDSB held across a 3-cycle stall while decode keeps changing.
        drive_id(1, 4'h7, 4'h1, 4'h2, 4'h3, 16'h1234, 16'h5678, 16'h0000, 0, 1, 0);
        @(posedge clk);
        #1;
        stall = 1;
        for (int c = 0; c < 3; c++) begin
            drive_id(1, 4'(c), 4'h9, 4'hA, 4'hB, 16'(16'hA000 + c), 16'hB000, 16'h0001, 1, 0, 1);
            @(posedge clk);
            #1;
            e = '{1, 4'h7, 4'h3, 16'h1234, 16'h5678, 1, 0, 1, 0};
            check_all($sformatf("stall%0d", c), e);
        end
        exmem_reg_write = 1; exmem_rd_addr = 4'h1; exmem_result = 16'hAAAA;
        #1;
        chk("stall.fwd_live", 32'(ex_alu_a), 32'hAAAA);
        clear_wb();
        stall = 0;
        drive_id(1, 4'h2, 4'h5, 4'h6, 4'h7, 16'h0055, 16'h0066, 16'h0000, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("release.opcode", 32'(ex_opcode), 32'h2);
        chk("release.psa", 32'(ex_is_psa), 32'd0);
        chk("release.alu_a", 32'(ex_alu_a), 32'h0055);

        // Reset while stalled clears the held entry.
        stall = 1; rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        e = '{0, 4'h0, 4'h0, 16'h0, 16'h0, 0, 0, 0, 0};
        check_all("rst_in_stall", e);
        stall = 0;
        idle_inputs();

        // R0 source with stale read data and an R0 writeback still yields zero.
        drive_id(1, 4'h0, 4'h0, 4'h1, 4'h2, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        memwb_reg_write = 1; memwb_rd_addr = 4'h0; memwb_result = 16'h5A5A;
        #1;
        chk("r0.alu_a", 32'(ex_alu_a), 32'h0000);
        chk("r0.alu_b", 32'(ex_alu_b), 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
